// File: rtl/tpmem_pkg.sv
// Shared constants and helpers for the ping-pong transpose memory.
package tpmem_pkg;

    localparam int unsigned TPMEM_N_MAX  = 32;
    localparam int unsigned TPMEM_BW_MAX = 32;
    localparam int unsigned TPMEM_W_MAX  = TPMEM_N_MAX * TPMEM_BW_MAX;

    // Ceiling log2, usable in constant expressions.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned res;
        res = 0;
        while (res < 32 && (32'd1 << res) < value) begin
            res = res + 1;
        end
        return res;
    endfunction

    // Element idx of an n-element word of bw-bit fields; element 0 sits in the MSBs.
    function automatic logic [TPMEM_BW_MAX-1:0] elem(
        input logic [TPMEM_W_MAX-1:0] word,
        input int unsigned            idx,
        input int unsigned            bw,
        input int unsigned            n
    );
        logic [TPMEM_W_MAX-1:0]  shifted;
        logic [TPMEM_BW_MAX-1:0] mask;
        shifted = word >> ((n - 1 - idx) * bw);
        mask    = TPMEM_BW_MAX'((64'd1 << bw) - 64'd1);
        return shifted[TPMEM_BW_MAX-1:0] & mask;
    endfunction

endpackage

// File: rtl/tpmem_bank.sv
// One N x N bank of BW-bit elements: row-wide write port, combinational read of
// either a column (mode_col=1) or a row (mode_col=0). Storage is not reset.
module tpmem_bank
    import tpmem_pkg::*;
#(
    parameter int unsigned  BW   = 11,
    parameter int unsigned  N    = 16,
    localparam int unsigned LOGN = clog2(N)
) (
    input  logic            clk,
    input  logic            we,
    input  logic [LOGN-1:0] waddr,
    input  logic [N*BW-1:0] wdata,
    input  logic [LOGN-1:0] rd_addr,
    input  logic            mode_col,
    output logic [N*BW-1:0] rd_data
);

    logic [N*BW-1:0] mem [N];

    // Row write, one whole row per enabled cycle.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Column gather across all rows, or a straight row read in pass-through mode.
    always_comb begin
        logic [TPMEM_W_MAX-1:0]  row_ext;
        logic [TPMEM_BW_MAX-1:0] e;
        row_ext = '0;
        e       = '0;
        rd_data = '0;
        if (mode_col) begin
            for (int r = 0; r < N; r++) begin
                row_ext              = '0;
                row_ext[N*BW-1:0]    = mem[r];
                e                    = elem(row_ext, 32'(rd_addr), BW, N);
                rd_data[(N-r)*BW-1 -: BW] = e[BW-1:0];
            end
        end else begin
            rd_data = mem[rd_addr];
        end
    end

endmodule

// File: rtl/tpmem_nxn_pp.sv
// Ping-pong N x N transpose memory: rows in, columns out, valid/ready on both sides.
// Optional feature macro: TPMEM_BYPASS_EN adds i_transpose (per-block row/column readout).
module tpmem_nxn_pp
    import tpmem_pkg::*;
#(
    parameter int unsigned BW = 11,
    parameter int unsigned N  = 16
) (
    input  logic            i_clk,
    input  logic            i_Reset,
    input  logic [N*BW-1:0] i_data,
    input  logic            i_enable,
    output logic            o_ready,
    output logic [N*BW-1:0] o_data,
    output logic            o_en,
    input  logic            i_ready
`ifdef TPMEM_BYPASS_EN
    ,
    input  logic            i_transpose
`endif
);

    localparam int unsigned     LOGN = clog2(N);
    localparam logic [LOGN-1:0] LAST = LOGN'(N - 1);

    logic [1:0]      full, full_next;
    logic            wsel, wsel_next;
    logic            rsel, rsel_next;
    logic [LOGN-1:0] wcnt, wcnt_next;
    logic [LOGN-1:0] rcnt, rcnt_next;
    logic [N*BW-1:0] data_next;
    logic            en_next;
    logic [N*BW-1:0] rd_data0, rd_data1;
    logic            wr_acc, can_load;
    logic [1:0]      mode_col;

`ifdef TPMEM_BYPASS_EN
    logic [1:0] col_mode, col_mode_next;
    assign mode_col = col_mode;
`else
    assign mode_col = 2'b11;
`endif

    assign o_ready  = !full[wsel];
    assign wr_acc   = i_enable && o_ready;
    // Output register may load when empty or when its word is being taken.
    assign can_load = !o_en || i_ready;

    tpmem_bank #(
        .BW (BW),
        .N  (N)
    ) u_bank0 (
        .clk      (i_clk),
        .we       (wr_acc && !wsel),
        .waddr    (wcnt),
        .wdata    (i_data),
        .rd_addr  (rcnt),
        .mode_col (mode_col[0]),
        .rd_data  (rd_data0)
    );

    tpmem_bank #(
        .BW (BW),
        .N  (N)
    ) u_bank1 (
        .clk      (i_clk),
        .we       (wr_acc && wsel),
        .waddr    (wcnt),
        .wdata    (i_data),
        .rd_addr  (rcnt),
        .mode_col (mode_col[1]),
        .rd_data  (rd_data1)
    );

    // Next state for write/read pointers, full flags and the output register.
    always_comb begin
        full_next = full;
        wsel_next = wsel;
        wcnt_next = wcnt;
        rsel_next = rsel;
        rcnt_next = rcnt;
        data_next = o_data;
        en_next   = o_en;
`ifdef TPMEM_BYPASS_EN
        col_mode_next = col_mode;
        if (wr_acc && wcnt == '0) begin
            col_mode_next[wsel] = i_transpose;
        end
`endif
        if (wr_acc) begin
            wcnt_next = wcnt + LOGN'(1);
            if (wcnt == LAST) begin
                full_next[wsel] = 1'b1;
                wsel_next       = !wsel;
            end
        end
        // Write only targets a non-full bank and read only a full one, so the
        // set and clear below can never hit the same bank.
        if (can_load) begin
            if (full[rsel]) begin
                data_next = rsel ? rd_data1 : rd_data0;
                en_next   = 1'b1;
                rcnt_next = rcnt + LOGN'(1);
                if (rcnt == LAST) begin
                    full_next[rsel] = 1'b0;
                    rsel_next       = !rsel;
                end
            end else begin
                data_next = '0;
                en_next   = 1'b0;
            end
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_Reset) begin
            full   <= 2'b00;
            wsel   <= 1'b0;
            rsel   <= 1'b0;
            wcnt   <= '0;
            rcnt   <= '0;
            o_data <= '0;
            o_en   <= 1'b0;
`ifdef TPMEM_BYPASS_EN
            col_mode <= 2'b11;
`endif
        end else begin
            full   <= full_next;
            wsel   <= wsel_next;
            rsel   <= rsel_next;
            wcnt   <= wcnt_next;
            rcnt   <= rcnt_next;
            o_data <= data_next;
            o_en   <= en_next;
`ifdef TPMEM_BYPASS_EN
            col_mode <= col_mode_next;
`endif
        end
    end

endmodule

// File: doc/tpmem_nxn_pp.md
# tpmem_nxn_pp

Parametrised ping-pong transpose memory for 2-D transform datapaths. It accepts an N×N block of BW-bit elements one row per cycle and emits the transposed block one column per cycle. Two banks let block k+1 be written while block k drains, so throughput is one row per cycle. A valid/ready handshake on both sides supports downstream stalls.

## Interface
- BW, 11, element width in bits (2..32)
- N, 16, block dimension; power of two, 4..32; LOGN = log2(N)
- i_clk  input  1  clock, rising edge
- i_Reset  input  1  reset, synchronous, active-low
- i_data  input  N*BW  row word; element j at bits [(N-j)*BW-1 : (N-j-1)*BW] (element 0 in MSBs)
- i_enable  input  1  row valid; accepted when i_enable && o_ready
- o_ready  output  1  write bank can accept a row (combinational from state)
- o_data  output  N*BW  column word, same packing; element r = row r
- o_en  output  1  o_data valid
- i_ready  input  1  downstream accepts o_data when o_en && i_ready
- i_transpose  input  1  only with TPMEM_BYPASS_EN; sampled per block

## Operation
- Two banks, each N×N×BW, with a per-bank full flag. Registers: wsel, rsel (1 bit), wcnt and rcnt (LOGN bits).
- Write: on accept, write bank[wsel] row wcnt <= i_data and increment wcnt. On wcnt==N-1: set full[wsel], toggle wsel, wrap wcnt to 0.
- o_ready = !full[wsel].
- Read: the output stage can load when !o_en || i_ready. If it can load and full[rsel]:
  - o_data <= column rcnt of bank[rsel]; o_en <= 1; increment rcnt.
  - On rcnt==N-1: clear full[rsel], toggle rsel, wrap rcnt.
- If the stage can load and !full[rsel]: o_en <= 0 and o_data <= 0.
- Stall: while o_en && !i_ready, o_data, o_en and rcnt hold.
- Simultaneous set/clear of full on different banks in one edge: both take effect. The same bank cannot be both set and cleared.
- Both banks full: o_ready=0; rows presented with i_enable are ignored, with no corruption.
- Bank storage is not reset. Outputs never expose unwritten storage, because reads require full.

## Timing
- Reset values: o_data=0, o_en=0, full=2'b00, wsel=rsel=0, wcnt=rcnt=0. o_ready=1 the cycle after reset.
- Reset mid-block: partial write and read blocks are discarded, with no output afterward until N new rows arrive.
- Latency: last row accepted at edge k means column 0 is on o_data with o_en=1 after edge k+1.
- With continuous input and i_ready=1: o_en stays high continuously after the first block, and o_ready never drops. When the last column of bank A loads, full[A] clears on the same edge that bank B fills.
- With i_ready held low: at most 2 blocks are buffered (plus 1 column in the output register), then o_ready=0.

## Configuration
- TPMEM_BYPASS_EN defined: the i_transpose port exists.
  - i_transpose is captured with the first row of each block and stored per bank.
  - 0: the bank is read out row by row (pass-through order).
  - 1: normal transpose.
- Undefined: no port; always transpose.

## Structure
- Package tpmem_pkg: functions clog2 and elem(word, idx, BW, N) slice helper; localparams TPMEM_N_MAX=32 and TPMEM_BW_MAX=32.
- Sub-module tpmem_bank (instantiated twice):
  - registers: row write port (we, waddr, wdata), per-row write enable only;
  - combinational read port: rd_addr, mode_col; outputs column rd_addr, or row rd_addr when mode_col=0.
- Top level holds the flags, counters, handshake and output register.

## Test plan
- N=16, BW=11, row r element c = r*16+c, 16 rows back-to-back, i_ready=1 -> 16 consecutive o_en cycles starting 1 cycle after the last row; column c element r = r*16+c.
- Four blocks continuous, with block b's values offset by b*256 -> o_en high 64 consecutive cycles with no bubble; o_ready stays 1 throughout.
- i_ready=0 from start, 3 blocks offered -> o_ready falls after 32 rows accepted; o_data holds column 0 of block 0; raising i_ready resumes in order with no lost or duplicated column.
- i_ready toggling 1010… -> each column held until accepted; column sequence 0..15 exact.
- Reset asserted after 7 rows of block 0, then a fresh 16-row block -> no o_en before the new block completes; output equals the transpose of the new block only.
- TPMEM_BYPASS_EN, block 0 with i_transpose=0, block 1 with i_transpose=1 -> block 0 emitted row-order, block 1 transposed.
